multiprec_seq: RTL and testbench

Multi-precision arithmetic sequencer that drives the 8-bit accumulator-carry add/subtract unit from the initiator side. It accepts an add, subtract or compare request on operands up to `MAX_BYTES` bytes wide and feeds them byte-serially, LSB first, into the byte ALU. It chains carries through the ALU's internal carry register and collects result bytes and flags. It sits between the datapath controller and the byte ALU and is the only block that drives the ALU's control lines.

---
 rtl/multiprec_seq.sv | 170 +++++++++++++++++
 tb/tb_multiprec_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiprec_seq.sv
// rtl/multiprec_seq.sv - byte-serial multi-precision add/sub/compare sequencer for the 8-bit carry ALU
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, op, nbytes     request strobe, operation (00 add, 01 sub, 10 compare, 11 add), length in bytes
//   opa, opb              operands, latched at start
//   busy, done            operation in flight / one-cycle completion pulse
//   result, zero, neg     sum or difference, all-bytes-zero flag, sign of the top processed byte
//   alu_a, alu_b          operand bytes to the ALU
//   alu_sub_sel           invert B and use carry-in 1 on the first byte
//   alu_csel              1: carry-in from sub_sel, 0: carry-in from the ALU's stored carry
//   alu_addsub            ALU latches its carry-out at posedge
//   alu_cmp               active-low ALU flag capture enable (negedge)
//   alu_sum, alu_sign     ALU combinational sum and registered sign flag
//   alu_z                 ALU registered zero flag (not needed here; zero is accumulated locally)
`timescale 1ns/1ps
module multiprec_seq #(
    parameter int      MAX_BYTES = 4,
    parameter realtime NAND_TIME = 7ns
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [2:0]             nbytes,
    input  logic [8*MAX_BYTES-1:0] opa,
    input  logic [8*MAX_BYTES-1:0] opb,
    output logic                   busy,
    output logic                   done,
    output logic [8*MAX_BYTES-1:0] result,
    output logic                   zero,
    output logic                   neg,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic                   alu_sub_sel,
    output logic                   alu_csel,
    output logic                   alu_addsub,
    output logic                   alu_cmp,
    input  logic [7:0]             alu_sum,
    input  logic                   alu_sign,
    input  logic                   alu_z
);

    localparam int         IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [3:0] MAX_N = 4'(MAX_BYTES);

    if (MAX_BYTES < 1 || MAX_BYTES > 8) begin : g_bad_max_bytes
        $error("multiprec_seq: MAX_BYTES must be 1..8");
    end
    if (NAND_TIME < 0.0) begin : g_bad_nand_time
        $error("multiprec_seq: NAND_TIME must not be negative");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                        state, state_nxt;
    logic [MAX_BYTES-1:0][7:0]     a_r, b_r, res_r;
    logic [IDX_W-1:0]              idx, last;
    logic                          sub_r, cmp_r, zacc;
    logic [3:0]                    n_eff;
    logic                          is_last, byte_zero;
    logic                          unused_alu_z;

    assign unused_alu_z = alu_z;
    assign is_last      = (idx == last);
    assign byte_zero    = (alu_sum == 8'h00);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign result       = res_r;

    // Length 0 means one byte; anything wider than the datapath is clamped.
    always_comb begin
        n_eff = {1'b0, nbytes};
        if (nbytes == 3'd0)
            n_eff = 4'd1;
        else if ({1'b0, nbytes} > MAX_N)
            n_eff = MAX_N;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_sub_sel = 1'b0;
        alu_csel    = 1'b1;
        alu_addsub  = 1'b0;
        alu_cmp     = 1'b1;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                alu_a       = a_r[idx];
                alu_b       = b_r[idx];
                alu_sub_sel = sub_r;
                // Byte 0 takes its carry-in from sub_sel, so a stale stored carry never leaks in.
                alu_csel    = (idx == '0);
                alu_addsub  = 1'b1;
                // Flags are only wanted from the most-significant processed byte.
                alu_cmp     = !is_last;
                if (is_last)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            idx   <= '0;
            last  <= '0;
            sub_r <= 1'b0;
            cmp_r <= 1'b0;
            zacc  <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= opa;
                        b_r   <= opb;
                        sub_r <= (op == 2'b01) || (op == 2'b10);
                        cmp_r <= (op == 2'b10);
                        last  <= IDX_W'(n_eff - 4'd1);
                        idx   <= '0;
                        zacc  <= 1'b1;
                    end
                end
                S_RUN: begin
                    zacc <= zacc & byte_zero;
                    if (!cmp_r) begin
                        for (int k = 0; k < MAX_BYTES; k++) begin
                            if (IDX_W'(k) == idx)
                                res_r[k] <= alu_sum;
                            else if (is_last && (IDX_W'(k) > idx))
                                res_r[k] <= 8'h00;
                        end
                    end
                    if (is_last) begin
                        // alu_sign was captured by the ALU at this cycle's negedge.
                        zero <= zacc & byte_zero;
                        neg  <= alu_sign;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiprec_seq.sv
// tb/tb_multiprec_seq.sv - self-checking bench for multiprec_seq with an 8-bit carry ALU model
`timescale 1ns/1ps
module tb_multiprec_seq;

    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [2:0]      nbytes = 3'd0;
    logic [8*MB-1:0] opa = '0;
    logic [8*MB-1:0] opb = '0;
    logic            busy, done, zero, neg;
    logic [8*MB-1:0] result;
    logic [7:0]      alu_a, alu_b, alu_sum;
    logic            alu_sub_sel, alu_csel, alu_addsub, alu_cmp;
    logic            alu_sign = 1'b0;
    logic            alu_z = 1'b0;

    always #5 clk = ~clk;

    multiprec_seq #(.MAX_BYTES(MB)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .nbytes(nbytes),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
        .zero(zero), .neg(neg), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sub_sel(alu_sub_sel), .alu_csel(alu_csel), .alu_addsub(alu_addsub),
        .alu_cmp(alu_cmp), .alu_sum(alu_sum), .alu_sign(alu_sign), .alu_z(alu_z)
    );

    // Byte ALU: combinational sum, carry register loaded at posedge, flags captured at negedge.
    logic       alu_carry = 1'b0;
    logic [7:0] alu_bx;
    logic       alu_c0;
    logic [8:0] alu_full;
    always_comb begin
        alu_bx   = alu_b ^ {8{alu_sub_sel}};
        alu_c0   = alu_csel ? alu_sub_sel : alu_carry;
        alu_full = {1'b0, alu_a} + {1'b0, alu_bx} + {8'd0, alu_c0};
    end
    assign alu_sum = alu_full[7:0];
    always @(posedge clk) if (alu_addsub) alu_carry <= alu_full[8];
    always @(negedge clk) if (!alu_cmp) begin
        alu_sign <= alu_full[7];
        alu_z    <= (alu_full[7:0] == 8'h00);
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: whole-word arithmetic on the effective length.
    function automatic int eff_len(input logic [2:0] nb);
        if (nb == 3'd0) return 1;
        if (int'(nb) > MB) return MB;
        return int'(nb);
    endfunction

    function automatic logic [63:0] lenmask(input int n);
        if (n >= 8) return '1;
        return (64'd1 << (8 * n)) - 64'd1;
    endfunction

    function automatic logic [63:0] calc(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b, input int n);
        if (o == 2'b01 || o == 2'b10) return (a - b) & lenmask(n);
        return (a + b) & lenmask(n);
    endfunction

    function automatic logic top_bit(input logic [63:0] v, input int n);
        return v[8 * n - 1];
    endfunction

    int          m_rem = 0;
    int          m_n = 1;
    logic [1:0]  m_op = 2'b00;
    logic [63:0] m_a = '0, m_b = '0;
    logic [63:0] exp_result = '0;
    logic        exp_zero = 1'b0, exp_neg = 1'b0;

    // m_rem counts the busy cycles still ahead: n RUN cycles plus the DONE cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem      <= 0;
            exp_result <= '0;
            exp_zero   <= 1'b0;
            exp_neg    <= 1'b0;
        end else if (m_rem == 0) begin
            if (start === 1'b1) begin
                m_op     <= op;
                m_a      <= 64'(opa);
                m_b      <= 64'(opb);
                m_n      <= eff_len(nbytes);
                m_rem    <= eff_len(nbytes) + 1;
                exp_zero <= (calc(op, 64'(opa), 64'(opb), eff_len(nbytes)) == 64'd0);
                exp_neg  <= top_bit(calc(op, 64'(opa), 64'(opb), eff_len(nbytes)), eff_len(nbytes));
                if (op != 2'b10)
                    exp_result <= calc(op, 64'(opa), 64'(opb), eff_len(nbytes));
            end
        end else begin
            m_rem <= m_rem - 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", busy, m_rem > 0);
            chk("done", done, m_rem == 1);
            if (m_rem <= 1) begin
                chk("result", result, exp_result);
                chk("zero", zero, exp_zero);
                chk("neg", neg, exp_neg);
                chk("alu_idle", {alu_a, alu_b, alu_sub_sel, alu_csel, alu_addsub, alu_cmp},
                    {16'h0000, 1'b0, 1'b1, 1'b0, 1'b1});
            end else begin
                chk("alu_run", {alu_a, alu_b, alu_sub_sel, alu_csel, alu_addsub, alu_cmp},
                    {m_a[8*(m_n+1-m_rem) +: 8], m_b[8*(m_n+1-m_rem) +: 8],
                     (m_op == 2'b01 || m_op == 2'b10), (m_n + 1 - m_rem) == 0, 1'b1,
                     (m_n + 1 - m_rem) != (m_n - 1)});
            end
        end
    end

    logic [8*MB-1:0] r_res;
    logic            r_zero, r_neg;
    int              r_cyc, r_busy;

    // r_cyc: cycle of done counted from the first busy cycle (1); r_busy: busy cycles seen.
    task automatic run_op(input logic [1:0] o, input logic [2:0] nb, input logic [31:0] a,
                          input logic [31:0] b, input bit pulse);
        @(negedge clk);
        op = o; nbytes = nb; opa = a; opb = b; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        r_cyc  = 1;
        r_busy = busy ? 1 : 0;
        while (!done && r_cyc < 30) begin
            @(negedge clk);
            r_cyc++;
            if (busy) r_busy++;
            if (pulse && r_cyc == 2) begin
                start = 1'b1;
                opa   = ~a;
            end else begin
                start = 1'b0;
            end
        end
        chk("done_seen", done, 1'b1);
        r_res  = result;
        r_zero = zero;
        r_neg  = neg;
        if (start) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {busy, done, zero, neg, result}, '0);

        run_op(2'b00, 3'd2, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        chk("add_carry_result", r_res, 32'h0000_0100);
        chk("add_carry_zero", r_zero, 1'b0);
        chk("add_carry_latency", r_cyc, 3);
        chk("add_carry_busy", r_busy, 3);

        run_op(2'b01, 3'd2, 32'h0000_0100, 32'h0000_0001, 1'b0);
        chk("sub_borrow_result", r_res, 32'h0000_00FF);
        chk("sub_borrow_flags", {r_zero, r_neg}, 2'b00);

        run_op(2'b10, 3'd2, 32'h0000_1234, 32'h0000_1234, 1'b0);
        chk("cmp_equal_flags", {r_zero, r_neg}, 2'b10);
        chk("cmp_equal_result_kept", r_res, 32'h0000_00FF);

        run_op(2'b10, 3'd2, 32'h0000_0001, 32'h0000_0002, 1'b0);
        chk("cmp_less_flags", {r_zero, r_neg}, 2'b01);

        run_op(2'b00, 3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        chk("wrap_result", r_res, 32'h0000_0000);
        chk("wrap_zero", r_zero, 1'b1);
        chk("wrap_latency", r_cyc, 5);

        run_op(2'b00, 3'd0, 32'h1122_3303, 32'h4455_6604, 1'b0);
        chk("len0_result", r_res, 32'h0000_0007);
        chk("len0_latency", r_cyc, 2);

        run_op(2'b00, 3'd7, 32'h0102_0304, 32'h1020_3040, 1'b1);
        chk("len7_result", r_res, 32'h1122_3344);
        chk("len7_latency", r_cyc, 5);

        run_op(2'b11, 3'd1, 32'h0000_0005, 32'h0000_0006, 1'b0);
        chk("op3_add_result", r_res, 32'h0000_000B);

        run_op(2'b00, 3'd1, 32'h0000_0080, 32'h0000_0001, 1'b1);
        chk("neg_add_flags", {r_zero, r_neg}, 2'b01);
        @(negedge clk);
        chk("start_in_done_ignored", busy, 1'b0);

        @(negedge clk);
        op = 2'b00; nbytes = 3'd2; opa = 32'h0000_00FF; opb = 32'h0000_0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {busy, done, result, zero, neg, alu_addsub, alu_csel, alu_cmp},
            {2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1});
        chk("stale_carry_present", alu_carry, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b00, 3'd2, 32'h0000_0001, 32'h0000_0001, 1'b0);
        chk("after_reset_result", r_res, 32'h0000_0002);
        chk("after_reset_latency", r_cyc, 3);

        for (int t = 0; t < 60; t++) begin
            logic [1:0] ro;
            logic [2:0] rn;
            ro = 2'($urandom_range(0, 3));
            rn = 3'($urandom_range(0, 7));
            run_op(ro, rn, $urandom, $urandom, $urandom_range(0, 3) == 0);
            chk("rand_latency", r_cyc, eff_len(rn) + 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
